// File: rtl/store_merge_unit_if.sv
// Store request and word-bus signal bundle between the memory stage, the store engine and the data bus.
interface store_merge_unit_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TYPE_W = 3;

    logic              st_valid_i;
    logic              st_ready_o;
    logic [ADDR_W-1:0] st_addr_i;
    logic [DATA_W-1:0] st_data_i;
    logic [TYPE_W-1:0] data_type_i;
    logic              stall_o;
    logic              done_o;
    logic              err_o;
    logic              bus_req_o;
    logic              bus_we_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic [DATA_W-1:0] bus_rdata_i;
    logic              bus_ack_i;

    modport slave (
        input  st_valid_i, st_addr_i, st_data_i, data_type_i, bus_rdata_i, bus_ack_i,
        output st_ready_o, stall_o, done_o, err_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o
    );

    modport master (
        output st_valid_i, st_addr_i, st_data_i, data_type_i, bus_rdata_i, bus_ack_i,
        input  st_ready_o, stall_o, done_o, err_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o
    );
endinterface

// File: rtl/store_merge_unit.sv
// Store engine for a word-only bus: word stores write directly, byte/half stores use read-modify-write.
module store_merge_unit (
    input  logic              clk,
    input  logic              rst,
    store_merge_unit_if.slave io
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TYPE_W = 3;
    localparam int unsigned HALF_W = 16;

    localparam logic [TYPE_W-1:0] T_BYTE  = TYPE_W'(0);
    localparam logic [TYPE_W-1:0] T_HALF  = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] T_WORD  = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] T_UBYTE = TYPE_W'(3);
    localparam logic [TYPE_W-1:0] T_UHALF = TYPE_W'(4);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_DONE, S_ERR} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_req, w_req_nxt;
    logic              r_we, w_we_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic              r_is_byte, w_is_byte_nxt;
    logic [1:0]        r_off, w_off_nxt;
    logic [HALF_W-1:0] r_sdata, w_sdata_nxt;
    logic              r_ready, r_stall, r_done, r_err;

    logic              w_type_byte, w_type_half, w_word_ok, w_half_ok;
    logic [DATA_W-1:0] w_merged;

    assign w_type_byte = (io.data_type_i == T_BYTE) || (io.data_type_i == T_UBYTE);
    assign w_type_half = (io.data_type_i == T_HALF) || (io.data_type_i == T_UHALF);
    assign w_word_ok   = (io.data_type_i == T_WORD) && (io.st_addr_i[1:0] == 2'b00);
    assign w_half_ok   = w_type_half && !io.st_addr_i[0];

    // Little-endian lane merge of the latched store data into the read word.
    always_comb begin
        w_merged = io.bus_rdata_i;
        if (r_is_byte) begin
            w_merged[{r_off, 3'b000} +: 8] = r_sdata[7:0];
        end else begin
            w_merged[{r_off[1], 4'b0000} +: HALF_W] = r_sdata;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_req_nxt     = r_req;
        w_we_nxt      = r_we;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_is_byte_nxt = r_is_byte;
        w_off_nxt     = r_off;
        w_sdata_nxt   = r_sdata;
        case (r_state)
            S_IDLE: begin
                if (io.st_valid_i) begin
                    if (w_word_ok) begin
                        w_state_nxt = S_WRITE;
                        w_req_nxt   = 1'b1;
                        w_we_nxt    = 1'b1;
                        w_addr_nxt  = {io.st_addr_i[ADDR_W-1:2], 2'b00};
                        w_wdata_nxt = io.st_data_i;
                    end else if (w_half_ok || w_type_byte) begin
                        w_state_nxt   = S_READ;
                        w_req_nxt     = 1'b1;
                        w_we_nxt      = 1'b0;
                        w_addr_nxt    = {io.st_addr_i[ADDR_W-1:2], 2'b00};
                        w_is_byte_nxt = w_type_byte;
                        w_off_nxt     = io.st_addr_i[1:0];
                        w_sdata_nxt   = io.st_data_i[HALF_W-1:0];
                    end else begin
                        w_state_nxt = S_ERR;
                    end
                end
            end
            S_READ: begin
                if (io.bus_ack_i) begin
                    w_state_nxt = S_WRITE;
                    w_we_nxt    = 1'b1;
                    w_wdata_nxt = w_merged;
                end
            end
            S_WRITE: begin
                if (io.bus_ack_i) begin
                    w_state_nxt = S_DONE;
                    w_req_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_is_byte <= 1'b0;
            r_off     <= 2'b00;
            r_sdata   <= '0;
            r_ready   <= 1'b1;
            r_stall   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_req     <= w_req_nxt;
            r_we      <= w_we_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_is_byte <= w_is_byte_nxt;
            r_off     <= w_off_nxt;
            r_sdata   <= w_sdata_nxt;
            r_ready   <= (w_state_nxt == S_IDLE);
            r_stall   <= (w_state_nxt == S_READ) || (w_state_nxt == S_WRITE) || (w_state_nxt == S_ERR);
            r_done    <= (w_state_nxt == S_DONE);
            r_err     <= (w_state_nxt == S_ERR);
        end
    end

    assign io.st_ready_o  = r_ready;
    assign io.stall_o     = r_stall;
    assign io.done_o      = r_done;
    assign io.err_o       = r_err;
    assign io.bus_req_o   = r_req;
    assign io.bus_we_o    = r_we;
    assign io.bus_addr_o  = r_addr;
    assign io.bus_wdata_o = r_wdata;
endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: word, RMW byte/half, misaligned, wait-state and reset scenarios.
module tb_store_merge_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    store_merge_unit_if bus_if();

    store_merge_unit dut (.clk(clk), .rst(rst), .io(bus_if));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive_req(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
        bus_if.st_valid_i  = 1'b1;
        bus_if.st_addr_i   = a;
        bus_if.st_data_i   = d;
        bus_if.data_type_i = t;
    endtask

    task automatic drop_req();
        bus_if.st_valid_i  = 1'b0;
        bus_if.st_addr_i   = 32'hFFFF_FFFF;
        bus_if.st_data_i   = 32'h0;
        bus_if.data_type_i = 3'd7;
    endtask

    // Zero-wait sub-word store: READ at T+1, WRITE at T+2, DONE at T+3, ready at T+4.
    task automatic rmw(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [2:0] t,
                       input logic [31:0] rd, input logic [31:0] exp_w);
        drive_req(a, d, t);
        chk({tag, " ready"}, 32'(bus_if.st_ready_o), 32'd1);
        tick();
        drop_req();
        chk({tag, " rd req"}, 32'(bus_if.bus_req_o), 32'd1);
        chk({tag, " rd we"}, 32'(bus_if.bus_we_o), 32'd0);
        chk({tag, " rd addr"}, bus_if.bus_addr_o, {a[31:2], 2'b00});
        bus_if.bus_ack_i   = 1'b1;
        bus_if.bus_rdata_i = rd;
        tick();
        bus_if.bus_rdata_i = 32'h0;
        chk({tag, " wr we"}, 32'(bus_if.bus_we_o), 32'd1);
        chk({tag, " wr addr"}, bus_if.bus_addr_o, {a[31:2], 2'b00});
        chk({tag, " wr data"}, bus_if.bus_wdata_o, exp_w);
        tick();
        bus_if.bus_ack_i = 1'b0;
        chk({tag, " done"}, {bus_if.done_o, bus_if.stall_o, bus_if.bus_req_o}, 32'b100);
        tick();
        chk({tag, " idle"}, {bus_if.st_ready_o, bus_if.done_o}, 32'b10);
    endtask

    task automatic bad_store(input string tag, input logic [31:0] a, input logic [2:0] t);
        drive_req(a, 32'h1234_5678, t);
        tick();
        drop_req();
        chk({tag, " err"}, {bus_if.err_o, bus_if.bus_req_o, bus_if.st_ready_o}, 32'b100);
        tick();
        chk({tag, " ready"}, {bus_if.err_o, bus_if.bus_req_o, bus_if.st_ready_o}, 32'b001);
    endtask

    // Zero-wait word store: write at T+1, DONE at T+2, ready at T+3.
    task automatic word_store(input string tag, input logic [31:0] a, input logic [31:0] d);
        drive_req(a, d, 3'd2);
        tick();
        drop_req();
        chk({tag, " wr"}, {31'(bus_if.bus_req_o), bus_if.bus_we_o}, 32'b11);
        chk({tag, " addr"}, bus_if.bus_addr_o, a);
        chk({tag, " wdata"}, bus_if.bus_wdata_o, d);
        chk({tag, " stall"}, 32'(bus_if.stall_o), 32'd1);
        bus_if.bus_ack_i = 1'b1;
        tick();
        bus_if.bus_ack_i = 1'b0;
        chk({tag, " done"}, {bus_if.done_o, bus_if.stall_o, bus_if.bus_req_o}, 32'b100);
        tick();
        chk({tag, " idle"}, {bus_if.st_ready_o, bus_if.done_o}, 32'b10);
    endtask

    initial begin
        drop_req();
        bus_if.bus_ack_i   = 1'b0;
        bus_if.bus_rdata_i = 32'h0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset ctl", {bus_if.st_ready_o, bus_if.stall_o, bus_if.done_o, bus_if.err_o,
                          bus_if.bus_req_o, bus_if.bus_we_o}, 32'b100000);
        chk("reset addr", bus_if.bus_addr_o, 32'h0);
        chk("reset wdata", bus_if.bus_wdata_o, 32'h0);

        word_store("word", 32'h100, 32'hDEAD_BEEF);
        rmw("byte", 32'h203, 32'h0000_00AB, 3'd0, 32'h1122_3344, 32'hAB22_3344);
        rmw("ubyte", 32'h203, 32'h0000_00AB, 3'd3, 32'h1122_3344, 32'hAB22_3344);
        rmw("half hi", 32'h302, 32'h0000_CAFE, 3'd1, 32'h1122_3344, 32'hCAFE_3344);
        rmw("half lo", 32'h300, 32'h0000_CAFE, 3'd1, 32'h1122_3344, 32'h1122_CAFE);
        rmw("uhalf", 32'h302, 32'hFFFF_BEEF, 3'd4, 32'h0000_0000, 32'hBEEF_0000);
        rmw("byte0", 32'h020, 32'hFFFF_FF5A, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FF5A);

        bad_store("mis word", 32'h102, 3'd2);
        bad_store("mis half", 32'h101, 3'd1);
        bad_store("bad type", 32'h100, 3'd7);

        // Wait states in both phases; a held request with new operands must be ignored while busy.
        drive_req(32'h401, 32'h0000_0055, 3'd0);
        tick();
        drive_req(32'h800, 32'h9999_9999, 3'd2);
        for (int i = 0; i < 3; i++) begin
            chk("wait rd", {bus_if.bus_req_o, bus_if.bus_we_o, bus_if.st_ready_o}, 32'b100);
            chk("wait rd addr", bus_if.bus_addr_o, 32'h400);
            tick();
        end
        bus_if.bus_ack_i   = 1'b1;
        bus_if.bus_rdata_i = 32'hAABB_CCDD;
        tick();
        bus_if.bus_ack_i   = 1'b0;
        bus_if.bus_rdata_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            chk("wait wr", {bus_if.bus_req_o, bus_if.bus_we_o, bus_if.stall_o}, 32'b111);
            chk("wait wr addr", bus_if.bus_addr_o, 32'h400);
            chk("wait wr data", bus_if.bus_wdata_o, 32'hAABB_55DD);
            tick();
        end
        drop_req();
        bus_if.bus_ack_i = 1'b1;
        tick();
        bus_if.bus_ack_i = 1'b0;
        chk("wait done", 32'(bus_if.done_o), 32'd1);
        tick();
        bus_if.bus_ack_i = 1'b1;
        tick();
        bus_if.bus_ack_i = 1'b0;
        chk("spurious ack", {bus_if.bus_req_o, bus_if.done_o, bus_if.st_ready_o}, 32'b001);

        // Reset in the middle of a WRITE drops the store.
        drive_req(32'h500, 32'h1234_5678, 3'd2);
        tick();
        drop_req();
        tick();
        chk("pre-rst wr", {bus_if.bus_req_o, bus_if.bus_we_o}, 32'b11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst mid wr", {bus_if.bus_req_o, bus_if.done_o, bus_if.stall_o, bus_if.st_ready_o}, 32'b0001);
        tick();
        chk("rst no done", 32'(bus_if.done_o), 32'd0);
        word_store("post rst", 32'h600, 32'hC0FF_EE00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
